// File: rtl/mul_iter.sv
// mul_iter: iterative limb-serial multiplier with low/signed-high/unsigned-high select and en/done/stall/flush handshake
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int LIMB  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_flush,
    input  logic             is_stall,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy
);
    localparam int N = WIDTH / LIMB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_abs, b_abs, b_sh;
    logic [1:0] op_r;
    logic neg, sgn, accept, last;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, row, sum, p;
    assign busy = state == CALC;
    always_comb begin
        sgn = op == 2'b01;
        accept = en && !is_flush && (state == IDLE || (state == DONE && !is_stall));
        last = busy && cnt == LAST;
        b_sh = b_abs >> (LIMB * cnt);
        row = ({{WIDTH{1'b0}}, a_abs} * {{(2*WIDTH-LIMB){1'b0}}, b_sh[LIMB-1:0]}) << (LIMB * cnt);
        sum = acc + row;
        p = neg ? -sum : sum;
        state_nxt = is_flush ? IDLE :
                    accept ? CALC :
                    last ? DONE :
                    (state == DONE && !is_stall) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            out   <= '0;
            a_abs <= '0;
            b_abs <= '0;
            neg   <= 1'b0;
            op_r  <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            done  <= state_nxt == DONE;
            if (accept) begin
                a_abs <= (sgn && a[WIDTH-1]) ? -a : a;
                b_abs <= (sgn && b[WIDTH-1]) ? -b : b;
                neg   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                op_r  <= op;
                cnt   <= '0;
                acc   <= '0;
            end else if (busy) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
            if (last && !is_flush)
                out <= (op_r == 2'b01 || op_r == 2'b10) ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed vectors and handshake corner cases on the default build, random runs on three builds
module tb_mul_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic is_flush[3], is_stall[3], en[3], done_v[3], busy_v[3];
    logic [1:0] op[3];
    logic [31:0] a[3], b[3];
    logic [31:0] out0, out1;
    logic [15:0] out2;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vecs[8];

    mul_iter u0 (.clk, .rst_n, .is_flush(is_flush[0]), .is_stall(is_stall[0]), .en(en[0]), .op(op[0]),
                 .a(a[0]), .b(b[0]), .out(out0), .done(done_v[0]), .busy(busy_v[0]));
    mul_iter #(.WIDTH(32), .LIMB(8)) u1 (.clk, .rst_n, .is_flush(is_flush[1]), .is_stall(is_stall[1]),
                 .en(en[1]), .op(op[1]), .a(a[1]), .b(b[1]), .out(out1), .done(done_v[1]), .busy(busy_v[1]));
    mul_iter #(.WIDTH(16), .LIMB(16)) u2 (.clk, .rst_n, .is_flush(is_flush[2]), .is_stall(is_stall[2]),
                 .en(en[2]), .op(op[2]), .a(a[2][15:0]), .b(b[2][15:0]), .out(out2), .done(done_v[2]), .busy(busy_v[2]));

    function automatic logic [31:0] get_out(input int k);
        return k == 0 ? out0 : k == 1 ? out1 : {16'h0, out2};
    endfunction

    function automatic logic [31:0] mask(input int w);
        return w == 32 ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] rnd(input int w);
        int s = $urandom_range(0, 7);
        logic [31:0] v = $urandom;
        if (s == 0) v = 32'd1 << (w - 1);
        if (s == 1) v = 32'hFFFF_FFFF;
        if (s == 2) v = 32'd0;
        return v & mask(w);
    endfunction

    // Full-width product of sign- or zero-extended operands, then pick the requested half
    function automatic logic [31:0] golden(input logic [31:0] x, y, input logic [1:0] o, input int w);
        logic [63:0] m64 = {32'h0, mask(w)};
        logic [63:0] ux = {32'h0, x} & m64;
        logic [63:0] uy = {32'h0, y} & m64;
        logic [63:0] p;
        if (o == 2'b01) begin
            if (x[w-1]) ux = ux | ~m64;
            if (y[w-1]) uy = uy | ~m64;
        end
        p = ux * uy;
        return (o == 2'b01 || o == 2'b10) ? 32'((p >> w) & m64) : 32'(p & m64);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, exp, input string name);
        int cyc, bc;
        op[0] = o; a[0] = x; b[0] = y; en[0] = 1'b1;
        step;
        en[0] = 1'b0;
        cyc = 1;
        bc = busy_v[0] ? 1 : 0;
        while (!done_v[0] && cyc < 12) begin
            step;
            cyc++;
            if (busy_v[0]) bc++;
        end
        chk({name, "_latency"}, cyc - 1, 2);
        chk({name, "_busy_cycles"}, bc, 2);
        chk({name, "_done"}, {31'h0, done_v[0]}, 1);
        chk({name, "_out"}, out0, exp);
    endtask

    task automatic run_random(input int k, input int w, input int n, input int iters, input logic [31:0] init_out);
        int m = 0, rem = 0;
        logic [31:0] pend = 0, exp = init_out, x, y;
        logic e, s, f;
        logic [1:0] o;
        for (int it = 0; it < iters; it++) begin
            e = 1'($urandom_range(0, 1));
            s = $urandom_range(0, 9) < 3;
            f = $urandom_range(0, 19) == 0;
            o = 2'($urandom_range(0, 3));
            x = rnd(w);
            y = rnd(w);
            en[k] = e; is_stall[k] = s; is_flush[k] = f; op[k] = o; a[k] = x; b[k] = y;
            step;
            if (f) m = 0;
            else if (m == 0) begin
                if (e) begin m = 1; rem = n; pend = golden(x, y, o, w); end
            end else if (m == 1) begin
                rem--;
                if (rem == 0) begin m = 2; exp = pend; end
            end else if (!s) begin
                if (e) begin m = 1; rem = n; pend = golden(x, y, o, w); end
                else m = 0;
            end
            chk($sformatf("rnd%0d_done", k), {31'h0, done_v[k]}, {31'h0, m == 2});
            chk($sformatf("rnd%0d_busy", k), {31'h0, busy_v[k]}, {31'h0, m == 1});
            chk($sformatf("rnd%0d_out", k), get_out(k), exp);
        end
        en[k] = 1'b0; is_stall[k] = 1'b0; is_flush[k] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5] = '{2'b11, 32'h1234_5678, 32'd9, 32'hA3D7_0A38};
        vecs[6] = '{2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF};
        vecs[7] = '{2'b10, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006};
        for (int k = 0; k < 3; k++) begin
            is_flush[k] = 1'b0; is_stall[k] = 1'b0; en[k] = 1'b0; op[k] = 2'b00; a[k] = '0; b[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) step;
        rst_n = 1'b1;
        chk("reset_done", {31'h0, done_v[0]}, 0);
        chk("reset_busy", {31'h0, busy_v[0]}, 0);
        chk("reset_out", out0, 0);
        chk("reset_out_u1", out1, 0);
        chk("reset_out_u2", {16'h0, out2}, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
            step;
            chk($sformatf("vec%0d_idle", i), {31'h0, done_v[0]}, 0);
        end

        run_op(2'b00, 32'd10, 32'd10, 32'd100, "pre_stall");
        for (int i = 0; i < 3; i++) begin
            is_stall[0] = 1'b1; en[0] = 1'b1; a[0] = $urandom; b[0] = $urandom; op[0] = 2'(i);
            step;
            chk("stall_done", {31'h0, done_v[0]}, 1);
            chk("stall_out", out0, 100);
        end
        is_stall[0] = 1'b0; en[0] = 1'b1; a[0] = 3; b[0] = 5; op[0] = 2'b00;
        step;
        en[0] = 1'b0;
        chk("release_done", {31'h0, done_v[0]}, 0);
        chk("release_busy", {31'h0, busy_v[0]}, 1);
        step;
        step;
        chk("release_done2", {31'h0, done_v[0]}, 1);
        chk("release_out", out0, 15);
        step;

        en[0] = 1'b1; a[0] = 100; b[0] = 100;
        step;
        en[0] = 1'b0; is_flush[0] = 1'b1;
        step;
        is_flush[0] = 1'b0;
        chk("flush_done", {31'h0, done_v[0]}, 0);
        chk("flush_busy", {31'h0, busy_v[0]}, 0);
        chk("flush_out", out0, 15);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("flush_hold_done", {31'h0, done_v[0]}, 0);
            chk("flush_hold_out", out0, 15);
        end
        en[0] = 1'b1; is_flush[0] = 1'b1;
        step;
        en[0] = 1'b0; is_flush[0] = 1'b0;
        chk("flush_en_busy", {31'h0, busy_v[0]}, 0);
        step;
        chk("flush_en_busy2", {31'h0, busy_v[0]}, 0);
        chk("flush_en_done", {31'h0, done_v[0]}, 0);
        chk("flush_en_out", out0, 15);

        en[0] = 1'b1; a[0] = 9; b[0] = 9;
        step;
        en[0] = 1'b0;
        chk("rst_pre_busy", {31'h0, busy_v[0]}, 1);
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("rst_mid_done", {31'h0, done_v[0]}, 0);
        chk("rst_mid_busy", {31'h0, busy_v[0]}, 0);
        chk("rst_mid_out", out0, 0);
        run_op(2'b00, 32'd6, 32'd7, 32'd42, "post_rst");
        step;

        run_random(0, 32, 2, 3000, 32'd42);
        run_random(1, 32, 4, 10000, 32'd0);
        run_random(2, 16, 1, 10000, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
